// File: rtl/core_issue_ctrl_pkg.sv
// Shared types and constants for the single-issue controller slice:
// opcode and state encodings, instruction field positions, watchdog limit.
// Imported by core_issue_ctrl and core_regfile.
package core_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_LOAD  = 4'd5,
    OP_STORE = 4'd6,
    OP_MUL   = 4'd7,
    OP_XOR   = 4'd8
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_ALU = 3'd2,
    S_WAIT_MEM = 3'd3,
    S_WB       = 3'd4
  } issue_state_t;

  // Instruction field positions
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 28;
  localparam int RD_MSB   = 27;
  localparam int RD_LSB   = 24;
  localparam int RSA_MSB  = 23;
  localparam int RSA_LSB  = 20;
  localparam int RSB_MSB  = 19;
  localparam int RSB_LSB  = 16;
  localparam int ADDR_MSB = 11;
  localparam int ADDR_LSB = 0;

  // Watchdog terminal count for the wait states
  localparam int TIMEOUT_MAX = 255;

  function automatic logic is_mem_op(input opcode_t op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/core_regfile.sv
// 16 x 8-bit register file: two combinational read ports, one synchronous
// write port, synchronous active-high reset clearing every entry.
// Ports: clk, rst, rd_a_addr/rd_a_data, rd_b_addr/rd_b_data, wr_en/wr_addr/wr_data.
module core_regfile
  import core_issue_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rd_a_addr,
  output logic [7:0] rd_a_data,
  input  logic [3:0] rd_b_addr,
  output logic [7:0] rd_b_data,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data
);

  logic [7:0] regs [16];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_a_data = regs[rd_a_addr];
  assign rd_b_data = regs[rd_b_addr];

endmodule

// File: rtl/core_issue_ctrl.sv
// Single-issue controller: accepts one instruction in IDLE, reads operands,
// dispatches to the ALU (level start_alu) or memory (one-cycle start pulses),
// waits for completion and writes the 8-bit truncated result back.
// Ports: instr_valid/instr/instr_ready handshake; alu_* / start_alu / end_alu /
// result_alu to the ALU; start_load/start_store/mem_addr/store_data/end_*/
// result_load to memory; wb_valid/wb_rd/wb_data writeback strobe; busy.
// Optional build macro ISSUE_TIMEOUT_EN adds an 8-bit wait-state watchdog and
// the timeout_err output; without it the FSM waits indefinitely.
module core_issue_ctrl
  import core_issue_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output opcode_t     alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        start_alu,
  input  logic        end_alu,
  input  logic [15:0] result_alu,
  output logic        start_load,
  output logic        start_store,
  output logic [11:0] mem_addr,
  output logic [7:0]  store_data,
  input  logic        end_load,
  input  logic        end_store,
  input  logic [15:0] result_load,
  output logic        wb_valid,
  output logic [3:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic        busy
`ifdef ISSUE_TIMEOUT_EN
  ,
  output logic        timeout_err
`endif
);

  issue_state_t state, state_nxt;

  // Captured instruction fields (bits [15:12] are reserved and dropped)
  opcode_t     op_q;
  logic [3:0]  rd_q, rsa_q, rsb_q;
  logic [11:0] addr_q;
  logic [15:0] result_q;

  logic [7:0]  rf_a, rf_b;
  logic        rf_we;
  logic        mem_done;
  logic        timeout_hit;
  logic        unused_rsvd;

  assign unused_rsvd = ^instr[15:12];

  // Only the completion matching the issued memory op counts
  assign mem_done = ((op_q == OP_LOAD)  && end_load) ||
                    ((op_q == OP_STORE) && end_store);

  core_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_a_addr (rsa_q),
    .rd_a_data (rf_a),
    .rd_b_addr (rsb_q),
    .rd_b_data (rf_b),
    .wr_en     (rf_we),
    .wr_addr   (rd_q),
    .wr_data   (result_q[7:0])
  );

`ifdef ISSUE_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       waiting;
  logic       done_now;

  assign waiting     = (state == S_WAIT_ALU) || (state == S_WAIT_MEM);
  assign done_now    = ((state == S_WAIT_ALU) && end_alu) ||
                       ((state == S_WAIT_MEM) && mem_done);
  assign timeout_hit = (wd_cnt == 8'(TIMEOUT_MAX));

  // Counter holds the number of cycles already spent in the current wait;
  // a completion in the terminal cycle still wins over the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd_cnt      <= waiting ? wd_cnt + 8'd1 : 8'd0;
      timeout_err <= waiting && timeout_hit && !done_now;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (instr_valid) state_nxt = S_ISSUE;
      S_ISSUE:    state_nxt = is_mem_op(op_q) ? S_WAIT_MEM : S_WAIT_ALU;
      S_WAIT_ALU: begin
        if (end_alu)          state_nxt = S_WB;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_WAIT_MEM: begin
        if (mem_done)         state_nxt = S_WB;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_WB:       state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    instr_ready = (state == S_IDLE);
    busy        = (state != S_IDLE);
    start_alu   = (state == S_WAIT_ALU);
    wb_valid    = (state == S_WB);
    wb_rd       = wb_valid ? rd_q : 4'd0;
    wb_data     = (wb_valid && (op_q != OP_STORE)) ? result_q : 16'd0;
    rf_we       = wb_valid && (op_q != OP_STORE);
  end

  // Instruction capture, operand registers, start pulses and result capture.
  // Operands are loaded on the ISSUE edge so they are valid alongside the
  // start request and remain stable through WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= OP_NOP;
      rd_q        <= '0;
      rsa_q       <= '0;
      rsb_q       <= '0;
      addr_q      <= '0;
      alu_op      <= OP_NOP;
      alu_a       <= '0;
      alu_b       <= '0;
      mem_addr    <= '0;
      store_data  <= '0;
      start_load  <= 1'b0;
      start_store <= 1'b0;
      result_q    <= '0;
    end else begin
      start_load  <= 1'b0;
      start_store <= 1'b0;
      if ((state == S_IDLE) && instr_valid) begin
        op_q   <= opcode_t'(instr[OPC_MSB:OPC_LSB]);
        rd_q   <= instr[RD_MSB:RD_LSB];
        rsa_q  <= instr[RSA_MSB:RSA_LSB];
        rsb_q  <= instr[RSB_MSB:RSB_LSB];
        addr_q <= instr[ADDR_MSB:ADDR_LSB];
      end
      if (state == S_ISSUE) begin
        alu_op      <= op_q;
        alu_a       <= rf_a;
        alu_b       <= rf_b;
        mem_addr    <= addr_q;
        store_data  <= rf_b;
        start_load  <= (op_q == OP_LOAD);
        start_store <= (op_q == OP_STORE);
        result_q    <= '0;  // STORE writes back zero
      end
      if ((state == S_WAIT_ALU) && end_alu)
        result_q <= result_alu;
      if ((state == S_WAIT_MEM) && (op_q == OP_LOAD) && end_load)
        result_q <= result_load;
    end
  end

endmodule
